// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_subtractor_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - bin, producing difference and borrow.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first,
// through a single full_subtractor cell and a stored borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    // Holds the WIDTH-1 most recent difference bits; the final bit joins
    // them combinationally on the last shift cycle.
    logic [WIDTH-2:0]   res_sr;
    logic               brw_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;

    logic               bit_d;
    logic               bit_bout;
    logic [WIDTH-1:0]   res_next;
    logic               accept;
    logic               last_bit;

    full_subtractor u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (brw_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign res_next = {bit_d, res_sr};
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (cnt_q == CNT_LAST);

    // State register; reset forces IDLE ahead of any start request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DONE can chain straight into a new SHIFT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded directly from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand PISOs, result SIPO, borrow flop, bit counter and output hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (state_q == SHIFT) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_next[WIDTH-1:1];
            brw_q  <= bit_bout;
            if (last_bit) begin
                cnt_q    <= '0;
                diff_q   <= res_next;
                borrow_q <= bit_bout;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): stimulus pushes the
// hand-computed result, a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int tests;
    int fails;
    logic [W:0]   sb_q[$];
    logic [W-1:0] held_diff;
    logic         held_brw;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expected {borrow, diff}.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [W:0] e;
                e = sb_q.pop_front();
                check("diff", int'(diff), int'(e[W-1:0]));
                check("borrow_out", int'(borrow_out), int'(e[W]));
            end
        end
    end

    // One operation; optional restart attempt with other operands mid-SHIFT.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb,
                         input bit inject, input string nm);
        int lat;
        int nbusy;
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        sb_q.push_back({eb, ed});
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) begin
                nbusy++;
                check({nm, "_hold"}, int'({borrow_out, diff}), int'({held_brw, held_diff}));
            end
            if (inject && lat == 2) begin
                start = 1'b1;
                a = ~av;
                b = ~bv;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({nm, "_latency"}, lat, W + 1);
        check({nm, "_busy_cycles"}, nbusy, W);
        held_diff = ed;
        held_brw  = eb;
    endtask

    initial begin
        int gap;
        tests = 0;
        fails = 0;
        held_diff = '0;
        held_brw  = 1'b0;
        reset = 1'b0;
        start = 1'b1;
        a = 4'd9;
        b = 4'd3;

        // Reset held with start asserted: reset must win.
        repeat (3) @(negedge clk);
        check("rst_diff", int'(diff), 0);
        check("rst_borrow", int'(borrow_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        do_op(4'd9,  4'd3, 4'd6,  1'b0, 1'b0, "9m3");
        do_op(4'd3,  4'd9, 4'hA,  1'b1, 1'b0, "3m9");
        do_op(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, "15m15");
        do_op(4'd0,  4'd1, 4'hF,  1'b1, 1'b0, "0m1");
        do_op(4'd10, 4'd3, 4'd7,  1'b0, 1'b1, "ignore");

        // Back-to-back: start held high, new operands at the DONE cycle.
        @(negedge clk);
        start = 1'b1;
        a = 4'd7;
        b = 4'd2;
        sb_q.push_back({1'b0, 4'd5});
        gap = 0;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_first_latency", gap, W + 1);
        a = 4'd5;
        b = 4'd5;
        sb_q.push_back({1'b0, 4'd0});
        gap = 0;
        @(negedge clk);
        gap++;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_period", gap, W + 1);
        start = 1'b0;
        @(negedge clk);
        check("b2b_back_idle", int'(busy || done), 0);
        held_diff = 4'd0;
        held_brw  = 1'b0;

        // Abort: reset on the second SHIFT cycle.
        @(negedge clk);
        start = 1'b1;
        a = 4'd6;
        b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_in_shift", int'(busy), 1);
        reset = 1'b0;
        a = 4'd3;
        b = 4'd1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_outputs", int'({borrow_out, diff}), 0);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        do_op(4'd12, 4'd4, 4'd8, 1'b0, 1'b0, "12m4");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (WIDTH >= 2).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only when idle or done.
REQ-005 Port: a  input  WIDTH  minuend, captured on accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 Port: diff  output  WIDTH  result a - b modulo 2^WIDTH, valid when done=1 and held until next accepted start.
REQ-008 Port: borrow_out  output  1  final borrow (1 iff a < b unsigned), same validity as diff.
REQ-009 Port: busy  output  1  high while bit-serial subtraction in progress.
REQ-010 Port: done  output  1  single-cycle pulse marking completion.

Function
REQ-011 FSM states IDLE, SHIFT, DONE; the state register resets to IDLE.
REQ-012 IDLE: start=1 -> load a, b into internal PISO registers, clear the borrow flop, clear the bit counter, go to SHIFT; start=0 -> stay.
REQ-013 SHIFT: each cycle, subtract the LSBs of both operand registers plus the stored borrow; shift the difference bit into the result SIPO from the MSB end; shift both operand registers right by one; update the borrow flop.
REQ-014 SHIFT lasts exactly WIDTH cycles; bit counter wraps to 0 on the last; then go to DONE.
REQ-015 Transfer diff and final borrow to the output registers on the transition into DONE.
REQ-016 DONE: done=1 for exactly one cycle; next state IDLE, or SHIFT if start=1 in that cycle (back-to-back operation, new operands loaded).
REQ-017 Latency: start accepted at edge N -> done=1 in cycle after edge N+WIDTH.
REQ-018 busy=1 exactly in SHIFT; start asserted while busy is ignored, with no effect on operands or timing.
REQ-019 Bit-level arithmetic: d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin); LSB first, initial borrow 0.
REQ-020 diff and borrow_out keep their previous values during SHIFT; they change only on entry to DONE or on reset.

Reset
REQ-021 With reset=0 at a rising edge, the block enters IDLE and sets diff=0, borrow_out=0, busy=0, done=0, counter=0, borrow flop=0, and clears all operand registers.
REQ-022 Reset mid-SHIFT aborts the operation; no done pulse follows, and outputs read 0.
REQ-023 Reset has priority over start in the same cycle.

Structure
REQ-024 A shared package holds the state enum (IDLE/SHIFT/DONE) and the WIDTH default constant.
REQ-025 The one-bit borrow logic lives in sub-module full_subtractor (ports x, y, bin, d, bout), instantiated once; FSM, counter, PISO/SIPO and borrow flop are in serial_subtractor.

Verification
REQ-026 WIDTH=4, a=9, b=3, start pulse -> done 4 cycles later, diff=6, borrow_out=0, busy high for 4 cycles.
REQ-027 a=3, b=9 -> diff=4'hA, borrow_out=1; a=15, b=15 -> diff=0, borrow_out=0; a=0, b=1 -> diff=4'hF, borrow_out=1.
REQ-028 start held high continuously with a=7, b=2 then a=5, b=5 presented at the DONE cycle -> consecutive done pulses every 5 cycles, diffs 5 then 0.
REQ-029 start re-pulsed with different operands during SHIFT -> ignored; result matches the original operands.
REQ-030 reset=0 asserted on the 2nd SHIFT cycle -> no done, all outputs 0 next cycle; a subsequent 12-4 operation returns diff=8, borrow_out=0.
